change_dispenser_fsm: RTL and testbench
=======================================

// Module: change_dispenser_fsm
// PURPOSE
//  Change-return engine for the vending FSM: the decode/output side of the coin encoder.
//  Takes a credit amount (in 5c units) to refund and breaks it greedily into coins.
//  For each coin it drives a 2-bit coin code plus the decoded one-hot release line.
//  Each coin is handshaked with the coin-tube mechanism.
//  Sits between the vend controller (request side) and the tube solenoid drivers.
// PARAMETERS
//  CREDIT_W     6    width of req_credit and the internal remaining-credit register (max 63 units)
//  ACK_TIMEOUT  255  cycles coin_valid may stay unacked before error (used only with CHANGE_TIMEOUT_EN)
// PORTS
//  clk           in   1         single clock, rising edge
//  rst_n         in   1         asynchronous, active-low reset
//  req_valid     in   1         refund request valid
//  req_ready     out  1         high only in IDLE; transfer on req_valid & req_ready
//  req_credit    in   CREDIT_W  units to refund (1 unit = 5c)
//  coin_valid    out  1         coin release request to tube mechanism
//  coin_code     out  2         encoded denomination: 00=1u, 01=2u, 10=5u, 11=10u
//  coin_release  out  4         one-hot decode of coin_code, gated by coin_valid (0000 when !coin_valid)
//  coin_ack      in   1         tube mechanism accepted the coin; sampled only while coin_valid=1
//  busy          out  1         high in every state except IDLE
//  done          out  1         one-cycle pulse when the refund completes
//  err           out  1         ack-timeout flag; tied 0 unless CHANGE_TIMEOUT_EN
// BEHAVIOUR
//  - rst_n low: state=IDLE, remaining=0, coin_code=00, coin_valid=0, coin_release=0, done=0,
//    err=0, busy=0, req_ready=1. Takes effect immediately, without a clock.
//  - States:
//    - IDLE: on accept, latch remaining=req_credit; go to DONE if it is 0, else to SELECT.
//    - SELECT (1 cycle): register coin_code = largest denomination <= remaining
//      (>=10 -> 11, >=5 -> 10, >=2 -> 01, else 00); go to ISSUE.
//    - ISSUE: coin_valid=1; coin_code and coin_release are held stable until coin_ack.
//      On coin_valid & coin_ack: remaining -= value(coin_code), then go to DONE if the
//      result is 0, else to SELECT.
//    - DONE (1 cycle): done=1; go to IDLE.
//  - coin_valid is always low for at least 1 cycle between coins, because every coin
//    passes through SELECT.
//  - Latency: accept at edge 0 -> SELECT cycle 1 -> coin_valid from cycle 2.
//    With same-cycle ack, each extra coin costs 2 cycles.
//    Zero credit: done in cycle 1, req_ready again in cycle 2.
//  - Arithmetic: the subtraction never underflows, because the denomination is chosen
//    <= remaining. Max 63 units -> 8 coins (6x10u, 1x2u, 1x1u).
//  - req_valid while busy: ignored, not queued.
//  - coin_ack outside ISSUE: ignored.
//  - rst_n asserted mid-refund: the remaining credit is discarded, coin_valid drops at
//    once, and no done pulse is produced.
// CONFIGURATION
//  CHANGE_TIMEOUT_EN defined:
//   - A counter clears on entry to ISSUE and increments each ISSUE cycle without coin_ack.
//   - When it reaches ACK_TIMEOUT, go to ERR: coin_valid=0, err=1, busy=1, req_ready=0.
//   - ERR exits to IDLE (err=0) on the first cycle with req_valid=1. That request is
//     not accepted.
//  CHANGE_TIMEOUT_EN undefined:
//   - No counter and no ERR state; ISSUE waits indefinitely; err is constant 0.
// TESTING
//  1 Reset: hold rst_n=0 mid-ISSUE -> coin_valid=0 at once.
//    After release -> req_ready=1, busy=0, done=0, coin_release=0000.
//  2 req_credit=7, coin_ack tied 1:
//    - cycle 2: code 10 / release 0100
//    - cycle 4: code 01 / release 0010
//    - done=1 in cycle 5, req_ready=1 in cycle 6.
//  3 req_credit=0 -> no coin_valid; done=1 in cycle 1; req_ready=1 in cycle 2.
//  4 req_credit=63, ack delayed 3 cycles per coin:
//    - coin sequence 11 x6, 01, 00
//    - each coin_valid high exactly 3 cycles, with the code stable throughout.
//    - Also check: req_valid pulses during the refund are ignored, and coin_ack
//      while !coin_valid is ignored.
//  5 Back-to-back: req_valid held high across two requests (9, then 2)
//    -> second accepted only in the IDLE cycle after done.
//    -> coin sequence 10, 01, 01, 01.
//  6 CHANGE_TIMEOUT_EN, ACK_TIMEOUT=4, req_credit=5, no ack:
//    - coin_valid high 4 cycles, then 0 and err=1.
//    - req_valid pulse -> IDLE, err=0, no coin issued.

Source files
------------

// File: rtl/change_dispenser_fsm.sv
// change_dispenser_fsm: greedy change-return engine issuing coins over a valid/ack handshake (optional ack timeout via CHANGE_TIMEOUT_EN)
module change_dispenser_fsm #(
  parameter int CREDIT_W    = 6,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CREDIT_W-1:0] req_credit,
  output logic                coin_valid,
  output logic [1:0]          coin_code,
  output logic [3:0]          coin_release,
  input  logic                coin_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, ERR} state_t;
  state_t state;
  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] coin_val;
  logic [1:0] best_code;
  assign coin_val = coin_code == 2'b11 ? CREDIT_W'(10) :
                    coin_code == 2'b10 ? CREDIT_W'(5)  :
                    coin_code == 2'b01 ? CREDIT_W'(2)  : CREDIT_W'(1);
  assign best_code = remaining >= CREDIT_W'(10) ? 2'b11 :
                     remaining >= CREDIT_W'(5)  ? 2'b10 :
                     remaining >= CREDIT_W'(2)  ? 2'b01 : 2'b00;
  assign coin_release = coin_valid ? 4'b0001 << coin_code : 4'b0000;
`ifdef CHANGE_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign err = 1'b0;
`endif
  // state machine with all handshake/status outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_code  <= 2'b00;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
`ifdef CHANGE_TIMEOUT_EN
      err        <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          remaining <= req_credit;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= req_credit == '0 ? DONE : SELECT;
          done      <= req_credit == '0;
        end
        SELECT: begin
          coin_code  <= best_code;
          coin_valid <= 1'b1;
          state      <= ISSUE;
`ifdef CHANGE_TIMEOUT_EN
          cnt        <= '0;
`endif
        end
        ISSUE: if (coin_ack) begin
          remaining  <= remaining - coin_val;
          coin_valid <= 1'b0;
          state      <= remaining == coin_val ? DONE : SELECT;
          done       <= remaining == coin_val;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          coin_valid <= 1'b0;
          err        <= 1'b1;
          state      <= ERR;
        end else cnt <= cnt + 1'b1;
        ERR: if (req_valid) begin
          err       <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
`endif
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser_fsm.sv
// tb_change_dispenser_fsm: randomized refunds checked against a greedy change model
module tb_change_dispenser_fsm;
  logic clk = 0, rst_n = 0, req_valid = 0, coin_ack = 0;
  logic [5:0] req_credit = '0;
  logic req_ready, coin_valid, busy, done, err;
  logic [1:0] coin_code;
  logic [3:0] coin_release;
  int errors = 0, checks = 0;

  change_dispenser_fsm #(.CREDIT_W(6), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_credit(req_credit), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_release(coin_release), .coin_ack(coin_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if ({req_ready, busy, done, coin_valid, coin_release, err} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0}) begin errors++; $display("FAIL reset_state: got %b want 1000_0000_0", {req_ready, busy, done, coin_valid, coin_release, err}); end
    req_valid = 1; req_credit = 6'd5;
    next_cycle();
    req_valid = 0;
    for (int i = 0; i < 10 && !coin_valid; i++) next_cycle();
    checks++; if (coin_valid !== 1'b1) begin errors++; $display("FAIL reset_setup: coin_valid got %b want 1", coin_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if ({coin_valid, coin_release} !== 5'b0) begin errors++; $display("FAIL reset_async: coin_valid/release got %b want 00000", {coin_valid, coin_release}); end
    next_cycle(); next_cycle();
    rst_n = 1;
    next_cycle();
    checks++; if ({req_ready, busy, done, coin_release} !== 7'b1000000) begin errors++; $display("FAIL reset_release: got %b want 1000000", {req_ready, busy, done, coin_release}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (done !== 1'b0 || coin_valid !== 1'b0) begin errors++; $display("FAIL reset_no_done: done=%b coin_valid=%b want 0 0", done, coin_valid); end
      next_cycle();
    end
  endtask

  // one refund with ack given in the dly-th cycle of each coin; noise adds stray req_valid/coin_ack
  task automatic run_refund(input int credit, input int dly, input bit noise, input string name);
    int exp_q[$], got_q[$];
    int r = credit, cyc = 1, hi = 0, done_cyc = -1, exp_done;
    logic [1:0] held = 2'b00;
    while (r > 0) begin
      if (r >= 10) begin exp_q.push_back(3); r -= 10; end
      else if (r >= 5) begin exp_q.push_back(2); r -= 5; end
      else if (r >= 2) begin exp_q.push_back(1); r -= 2; end
      else begin exp_q.push_back(0); r -= 1; end
    end
    exp_done = exp_q.size() * (1 + dly) + 1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_idle: req_ready got %b want 1", name, req_ready); end
    req_valid = 1; req_credit = 6'(credit);
    next_cycle();
    req_valid = 0;
    while (cyc < 400) begin
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL %s_busy c%0d: busy=%b req_ready=%b want 1 0", name, cyc, busy, req_ready); end
      if (done === 1'b1) begin done_cyc = cyc; break; end
      if (coin_valid === 1'b1) begin
        if (hi == 0) begin got_q.push_back(int'(coin_code)); held = coin_code; end
        else begin checks++; if (coin_code !== held) begin errors++; $display("FAIL %s_stable c%0d: code got %b want %b", name, cyc, coin_code, held); end end
        checks++; if (coin_release !== (4'b0001 << coin_code)) begin errors++; $display("FAIL %s_release c%0d: got %b for code %b", name, cyc, coin_release, coin_code); end
        hi++;
        coin_ack = (hi == dly);
      end else begin
        if (hi != 0) begin checks++; if (hi != dly) begin errors++; $display("FAIL %s_width: coin_valid cycles got %0d want %0d", name, hi, dly); end end
        hi = 0;
        checks++; if (coin_release !== 4'b0) begin errors++; $display("FAIL %s_release_idle c%0d: got %b want 0000", name, cyc, coin_release); end
        coin_ack = noise ? 1'($urandom) : 1'b0;
      end
      req_valid = noise ? 1'($urandom) : 1'b0;
      req_credit = 6'($urandom);
      next_cycle();
      cyc++;
    end
    req_valid = 0; coin_ack = 0;
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, exp_done); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_coin_count: got %0d want %0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL %s_coin%0d: code got %0d want %0d", name, i, got_q[i], exp_q[i]); end
    end
    next_cycle();
    checks++; if ({req_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL %s_back_idle: got %b want 100", name, {req_ready, busy, done}); end
  endtask

  task automatic test_back_to_back();
    int got_q[$], ready_q[$], done_q[$];
    int exp_q[$] = '{2, 1, 1, 1};
    logic prev_cv = 0;
    coin_ack = 1; req_valid = 1; req_credit = 6'd9;
    next_cycle();
    req_credit = 6'd2;
    for (int cyc = 1; cyc < 40 && done_q.size() < 2; cyc++) begin
      if (coin_valid && !prev_cv) got_q.push_back(int'(coin_code));
      prev_cv = coin_valid;
      if (req_ready) ready_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      next_cycle();
    end
    req_valid = 0; coin_ack = 0;
    checks++; if (ready_q.size() != 1 || ready_q[0] != 8) begin errors++; $display("FAIL b2b_ready: got %0d cycles first=%0d want 1 at 8", ready_q.size(), ready_q.size() ? ready_q[0] : -1); end
    checks++; if (done_q.size() != 2 || done_q[0] != 7 || done_q[1] != 11) begin errors++; $display("FAIL b2b_done: got %0d pulses want 2 at 7,11", done_q.size()); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL b2b_coin%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    next_cycle();
    checks++; if ({req_ready, busy} !== 2'b10) begin errors++; $display("FAIL b2b_idle: got %b want 10", {req_ready, busy}); end
  endtask

`ifdef CHANGE_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    req_valid = 1; req_credit = 6'd5;
    next_cycle();
    req_valid = 0;
    for (int i = 0; i < 20 && !err; i++) begin
      if (coin_valid) hi++;
      next_cycle();
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL timeout_width: got %0d want 4", hi); end
    checks++; if ({err, coin_valid, busy, req_ready} !== 4'b1010) begin errors++; $display("FAIL timeout_err: got %b want 1010", {err, coin_valid, busy, req_ready}); end
    req_valid = 1;
    next_cycle();
    req_valid = 0;
    checks++; if ({err, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL timeout_exit: got %b want 001", {err, busy, req_ready}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (coin_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_no_coin: coin_valid=%b busy=%b want 0 0", coin_valid, busy); end
      next_cycle();
    end
  endtask
`endif

  initial begin
    #22 rst_n = 1;
    next_cycle();
    test_reset();
    run_refund(7, 1, 0, "credit7");
    run_refund(0, 1, 0, "credit0");
    run_refund(63, 3, 1, "credit63");
    test_back_to_back();
    for (int i = 0; i < 25; i++) run_refund(int'($urandom_range(63, 0)), int'($urandom_range(4, 1)), 1, "random");
`ifdef CHANGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
